// File: rtl/pilha_pkg.sv
// ============================================================================
// Module  : pilha_pkg
// Brief   : Shared widths, FSM encoding and request priority for the stack path
// Rev     : 1.0
// ============================================================================
`default_nettype none

package pilha_pkg;

  localparam int PILHA_DATA_W = 16;
  localparam int PILHA_ADDR_W = 5;
  localparam int PILHA_DEPTH  = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PUSH_WR = 3'd1,
    ST_RD1     = 3'd2,
    ST_WAIT1   = 3'd3,
    ST_RD2     = 3'd4,
    ST_WAIT2   = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_PUSH = 2'd1,
    REQ_POP2 = 2'd2,
    REQ_POP  = 2'd3
  } req_t;

  // Push outranks pop2, which outranks pop.
  function automatic req_t req_sel(input logic push, input logic pop, input logic pop2);
    if (push)      return REQ_PUSH;
    else if (pop2) return REQ_POP2;
    else if (pop)  return REQ_POP;
    else           return REQ_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pilha_ctrl.sv
// ============================================================================
// Module  : pilha_ctrl
// Brief   : Stack controller: sequences the single-port stack RAM for push,
//           pop and pop-two requests and tracks the stack pointer.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module pilha_ctrl
  import pilha_pkg::*;
#(
  parameter int DATA_W = PILHA_DATA_W,
  parameter int ADDR_W = PILHA_ADDR_W,
  parameter int DEPTH  = PILHA_DEPTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_push,
  input  logic              req_pop,
  input  logic              req_pop2,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] mem_q,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [ADDR_W:0]   sp,
  output logic              full,
  output logic              empty,
  output logic              busy,
  output logic              done,
  output logic              overflow_err,
  output logic              underflow_err
);

  localparam logic [ADDR_W:0] SP_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] SP_TWO  = (ADDR_W + 1)'(2);

  state_t            state, state_n;
  logic              pop2_mode, pop2_mode_n;
  logic [ADDR_W:0]   sp_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] data_n, op_a_n, op_b_n;
  logic              wren_n, done_n, ovf_n, unf_n;
  logic [ADDR_W-1:0] top_addr;
  req_t              req;

  assign full     = (sp == SP_FULL);
  assign empty    = (sp == '0);
  assign busy     = (state != ST_IDLE);
  assign top_addr = sp[ADDR_W-1:0] - ADDR_W'(1);
  assign req      = req_sel(req_push, req_pop, req_pop2);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      pop2_mode     <= 1'b0;
      sp            <= '0;
      mem_addr      <= '0;
      mem_data      <= '0;
      mem_wren      <= 1'b0;
      op_a          <= '0;
      op_b          <= '0;
      done          <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      state         <= state_n;
      pop2_mode     <= pop2_mode_n;
      sp            <= sp_n;
      mem_addr      <= addr_n;
      mem_data      <= data_n;
      mem_wren      <= wren_n;
      op_a          <= op_a_n;
      op_b          <= op_b_n;
      done          <= done_n;
      overflow_err  <= ovf_n;
      underflow_err <= unf_n;
    end
  end

  // Registered outputs are computed one state ahead, so e.g. mem_wren is
  // raised on the edge that enters PUSH_WR and dropped on the edge leaving it.
  always_comb begin
    state_n     = state;
    pop2_mode_n = pop2_mode;
    sp_n        = sp;
    addr_n      = mem_addr;
    data_n      = mem_data;
    op_a_n      = op_a;
    op_b_n      = op_b;
    wren_n      = 1'b0;
    done_n      = 1'b0;
    ovf_n       = overflow_err;
    unf_n       = underflow_err;

    case (state)
      ST_IDLE: begin
        if (req != REQ_NONE) begin
          ovf_n  = 1'b0;
          unf_n  = 1'b0;
          data_n = data_in;
        end
        case (req)
          REQ_PUSH: begin
            if (full) begin
              ovf_n   = 1'b1;
              done_n  = 1'b1;
              state_n = ST_DONE;
            end else begin
              addr_n  = sp[ADDR_W-1:0];
              wren_n  = 1'b1;
              state_n = ST_PUSH_WR;
            end
          end
          REQ_POP2: begin
            if (sp < SP_TWO) begin
              unf_n   = 1'b1;
              done_n  = 1'b1;
              state_n = ST_DONE;
            end else begin
              pop2_mode_n = 1'b1;
              addr_n      = top_addr;
              state_n     = ST_RD1;
            end
          end
          REQ_POP: begin
            if (empty) begin
              unf_n   = 1'b1;
              done_n  = 1'b1;
              state_n = ST_DONE;
            end else begin
              pop2_mode_n = 1'b0;
              addr_n      = top_addr;
              state_n     = ST_RD1;
            end
          end
          default: ;
        endcase
      end

      ST_PUSH_WR: begin
        sp_n    = sp + 1'b1;
        done_n  = 1'b1;
        state_n = ST_DONE;
      end

      ST_RD1: state_n = ST_WAIT1;

      ST_WAIT1: begin
        sp_n = sp - 1'b1;
        if (pop2_mode) begin
          op_b_n  = mem_q;
          addr_n  = top_addr - ADDR_W'(1);
          state_n = ST_RD2;
        end else begin
          op_a_n  = mem_q;
          done_n  = 1'b1;
          state_n = ST_DONE;
        end
      end

      ST_RD2: state_n = ST_WAIT2;

      ST_WAIT2: begin
        op_a_n  = mem_q;
        sp_n    = sp - 1'b1;
        done_n  = 1'b1;
        state_n = ST_DONE;
      end

      ST_DONE: state_n = ST_IDLE;

      default: state_n = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_pilha_ctrl.sv
// ============================================================================
// Module  : tb_pilha_ctrl
// Brief   : Self-checking bench for pilha_ctrl against a queue-based stack model
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_pilha_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_push = 1'b0, req_pop = 1'b0, req_pop2 = 1'b0;
  logic [15:0] data_in = '0;
  logic [15:0] mem_q;
  logic [4:0]  mem_addr;
  logic [15:0] mem_data;
  logic        mem_wren;
  logic [15:0] op_a, op_b;
  logic [5:0]  sp;
  logic        full, empty, busy, done, overflow_err, underflow_err;

  pilha_ctrl dut (
    .clock(clock), .reset(reset),
    .req_push(req_push), .req_pop(req_pop), .req_pop2(req_pop2),
    .data_in(data_in), .mem_q(mem_q),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
    .op_a(op_a), .op_b(op_b), .sp(sp),
    .full(full), .empty(empty), .busy(busy), .done(done),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 clock = ~clock;

  // Synchronous single-port stack RAM, one-cycle read latency
  logic [15:0] ram [32];
  always @(posedge clock) begin
    if (mem_wren) ram[mem_addr] <= mem_data;
    mem_q <= ram[mem_addr];
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the stack as a queue, plus the operand and error state
  logic [15:0] m_stack[$];
  logic [15:0] m_op_a, m_op_b;
  logic        m_ovf, m_unf;

  task automatic model_reset();
    m_stack.delete();
    m_op_a = '0; m_op_b = '0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  // kind: 0 push, 1 pop, 2 pop2, 3 push+pop together. Returns latency.
  function automatic int model_apply(input int kind, input logic [15:0] d,
                                     output bit exp_wr, output logic [4:0] exp_addr);
    exp_wr = 1'b0; exp_addr = '0;
    m_ovf = 1'b0; m_unf = 1'b0;
    if (kind == 0 || kind == 3) begin
      if (m_stack.size() == 32) begin m_ovf = 1'b1; return 1; end
      exp_wr = 1'b1; exp_addr = 5'(m_stack.size());
      m_stack.push_back(d);
      return 2;
    end else if (kind == 1) begin
      if (m_stack.size() < 1) begin m_unf = 1'b1; return 1; end
      m_op_a = m_stack.pop_back();
      return 3;
    end else begin
      if (m_stack.size() < 2) begin m_unf = 1'b1; return 1; end
      m_op_b = m_stack.pop_back();
      m_op_a = m_stack.pop_back();
      return 5;
    end
  endfunction

  task automatic do_reset();
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    model_reset();
  endtask

  // Issues one request and measures it; lat = -1 when done never arrives.
  task automatic issue(input int kind, input logic [15:0] d, input bit noise,
                       output int lat, output int nwr,
                       output logic [4:0] waddr, output logic [15:0] wdata);
    int guard;
    guard = 0; lat = 0; nwr = 0; waddr = '0; wdata = '0;
    @(negedge clock);
    while (busy && guard < 50) begin @(negedge clock); guard++; end
    data_in  = d;
    req_push = (kind == 0 || kind == 3);
    req_pop  = (kind == 1 || kind == 3);
    req_pop2 = (kind == 2);
    @(posedge clock); #1;
    lat = 1;
    req_push = noise; req_pop = noise; req_pop2 = noise;
    if (noise) data_in = 16'hDEAD;
    while (1) begin
      if (mem_wren) begin nwr++; waddr = mem_addr; wdata = mem_data; end
      if (done) break;
      if (lat >= 20) begin lat = -1; break; end
      @(posedge clock); #1;
      lat++;
    end
    req_push = 1'b0; req_pop = 1'b0; req_pop2 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; #1;
    n_checks++;
    if ({sp, empty, full, busy, done, mem_wren, overflow_err, underflow_err} !== {6'd0, 1'b1, 6'b0})
      $display("FAIL reset_status got sp=%0d e=%b f=%b b=%b d=%b w=%b ov=%b un=%b want sp=0 e=1 rest 0",
               sp, empty, full, busy, done, mem_wren, overflow_err, underflow_err);
    else n_pass++;
    n_checks++;
    if ({mem_addr, mem_data, op_a, op_b} !== '0)
      $display("FAIL reset_regs got addr=%h data=%h a=%h b=%h want all 0", mem_addr, mem_data, op_a, op_b);
    else n_pass++;
    @(negedge clock); reset = 1'b0;
    model_reset();
  endtask

  task automatic test_push_basic();
    int lat, nwr, el; bit ew; logic [4:0] wa, ea; logic [15:0] wd;
    el = model_apply(0, 16'h00A5, ew, ea);
    issue(0, 16'h00A5, 1'b0, lat, nwr, wa, wd);
    n_checks++;
    if (lat !== el) $display("FAIL push_latency got %0d want %0d", lat, el); else n_pass++;
    n_checks++;
    if (nwr !== 1 || wa !== 5'd0 || wd !== 16'h00A5)
      $display("FAIL push_write got n=%0d addr=%0d data=%h want n=1 addr=0 data=00a5", nwr, wa, wd);
    else n_pass++;
    n_checks++;
    if (sp !== 6'd1 || empty !== 1'b0) $display("FAIL push_sp got sp=%0d empty=%b want 1/0", sp, empty);
    else n_pass++;
  endtask

  task automatic test_pop2();
    int lat, nwr, el; bit ew; logic [4:0] wa, ea; logic [15:0] wd;
    do_reset();
    el = model_apply(0, 16'h0007, ew, ea); issue(0, 16'h0007, 1'b0, lat, nwr, wa, wd);
    el = model_apply(0, 16'h0003, ew, ea); issue(0, 16'h0003, 1'b0, lat, nwr, wa, wd);
    el = model_apply(2, 16'h0000, ew, ea); issue(2, 16'h0000, 1'b0, lat, nwr, wa, wd);
    n_checks++;
    if (lat !== el) $display("FAIL pop2_latency got %0d want %0d", lat, el); else n_pass++;
    n_checks++;
    if (op_b !== m_op_b || op_a !== m_op_a)
      $display("FAIL pop2_operands got a=%h b=%h want a=%h b=%h", op_a, op_b, m_op_a, m_op_b);
    else n_pass++;
    n_checks++;
    if (sp !== 6'd0 || nwr !== 0) $display("FAIL pop2_sp_wren got sp=%0d writes=%0d want 0/0", sp, nwr);
    else n_pass++;
  endtask

  task automatic test_underflow();
    int lat, nwr, el; bit ew; logic [4:0] wa, ea; logic [15:0] wd;
    el = model_apply(1, 16'h0000, ew, ea);
    issue(1, 16'h0000, 1'b0, lat, nwr, wa, wd);
    n_checks++;
    if (lat !== el || underflow_err !== 1'b1)
      $display("FAIL pop_empty got lat=%0d unf=%b want lat=%0d unf=1", lat, underflow_err, el);
    else n_pass++;
    n_checks++;
    if (sp !== 6'd0 || op_a !== m_op_a) $display("FAIL pop_empty_state got sp=%0d a=%h want 0/%h", sp, op_a, m_op_a);
    else n_pass++;
    el = model_apply(0, 16'h1234, ew, ea);
    issue(0, 16'h1234, 1'b0, lat, nwr, wa, wd);
    n_checks++;
    if (underflow_err !== 1'b0) $display("FAIL unf_clear got %b want 0", underflow_err); else n_pass++;
  endtask

  task automatic test_fill_overflow();
    int lat, nwr, el, bad; bit ew; logic [4:0] wa, ea; logic [15:0] wd;
    do_reset();
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      el = model_apply(0, 16'(i), ew, ea);
      issue(0, 16'(i), 1'b0, lat, nwr, wa, wd);
      if (lat !== el || nwr !== 1 || wa !== ea) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL fill_pushes got %0d bad pushes want 0", bad); else n_pass++;
    n_checks++;
    if (full !== 1'b1 || sp !== 6'd32) $display("FAIL fill_full got full=%b sp=%0d want 1/32", full, sp);
    else n_pass++;
    el = model_apply(0, 16'hBEEF, ew, ea);
    issue(0, 16'hBEEF, 1'b0, lat, nwr, wa, wd);
    n_checks++;
    if (overflow_err !== 1'b1 || nwr !== 0 || lat !== el || sp !== 6'd32)
      $display("FAIL overflow got ovf=%b writes=%0d lat=%0d sp=%0d want 1/0/%0d/32", overflow_err, nwr, lat, sp, el);
    else n_pass++;
    el = model_apply(1, 16'h0000, ew, ea);
    issue(1, 16'h0000, 1'b0, lat, nwr, wa, wd);
    n_checks++;
    if (op_a !== m_op_a || lat !== el || overflow_err !== 1'b0)
      $display("FAIL pop_after_full got a=%h lat=%0d ovf=%b want %h/%0d/0", op_a, lat, overflow_err, m_op_a, el);
    else n_pass++;
  endtask

  task automatic test_short_pop2_priority();
    int lat, nwr, el; bit ew; logic [4:0] wa, ea; logic [15:0] wd;
    do_reset();
    el = model_apply(0, 16'h0055, ew, ea); issue(0, 16'h0055, 1'b0, lat, nwr, wa, wd);
    el = model_apply(2, 16'h0000, ew, ea); issue(2, 16'h0000, 1'b0, lat, nwr, wa, wd);
    n_checks++;
    if (underflow_err !== 1'b1 || sp !== 6'd1 || lat !== el)
      $display("FAIL pop2_short got unf=%b sp=%0d lat=%0d want 1/1/%0d", underflow_err, sp, lat, el);
    else n_pass++;
    el = model_apply(3, 16'h0066, ew, ea); issue(3, 16'h0066, 1'b0, lat, nwr, wa, wd);
    n_checks++;
    if (lat !== el || nwr !== 1 || wd !== 16'h0066 || sp !== 6'd2)
      $display("FAIL push_priority got lat=%0d writes=%0d data=%h sp=%0d want %0d/1/0066/2", lat, nwr, wd, sp, el);
    else n_pass++;
    el = model_apply(2, 16'h0000, ew, ea); issue(2, 16'h0000, 1'b1, lat, nwr, wa, wd);
    n_checks++;
    if (lat !== el || nwr !== 0 || op_a !== m_op_a || op_b !== m_op_b)
      $display("FAIL busy_ignore got lat=%0d writes=%0d a=%h b=%h want %0d/0/%h/%h",
               lat, nwr, op_a, op_b, el, m_op_a, m_op_b);
    else n_pass++;
    repeat (2) @(posedge clock); #1;
    n_checks++;
    if (busy !== 1'b0 || sp !== 6'd0) $display("FAIL busy_ignore_idle got busy=%b sp=%0d want 0/0", busy, sp);
    else n_pass++;
  endtask

  task automatic test_reset_midop();
    int lat, nwr, el; bit ew; logic [4:0] wa, ea; logic [15:0] wd;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      el = model_apply(0, 16'(16'h0100 + i), ew, ea);
      issue(0, 16'(16'h0100 + i), 1'b0, lat, nwr, wa, wd);
    end
    el = model_apply(2, 16'h0000, ew, ea); issue(2, 16'h0000, 1'b0, lat, nwr, wa, wd);
    el = model_apply(0, 16'h0200, ew, ea); issue(0, 16'h0200, 1'b0, lat, nwr, wa, wd);
    el = model_apply(0, 16'h0201, ew, ea); issue(0, 16'h0201, 1'b0, lat, nwr, wa, wd);
    @(negedge clock);
    req_pop2 = 1'b1;
    @(posedge clock); #1; req_pop2 = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1; #1;
    n_checks++;
    if ({sp, empty, busy, done, mem_wren} !== {6'd0, 1'b1, 1'b0, 1'b0, 1'b0} || op_a !== '0 || op_b !== '0)
      $display("FAIL reset_midop got sp=%0d e=%b b=%b d=%b w=%b a=%h b=%h want 0/1/0/0/0/0/0",
               sp, empty, busy, done, mem_wren, op_a, op_b);
    else n_pass++;
    @(negedge clock); reset = 1'b0;
    model_reset();
  endtask

  task automatic test_random();
    int lat, nwr, el, kind, r; bit ew; logic [4:0] wa, ea; logic [15:0] wd, d;
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 9));
      kind = (r < 5) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3;
      d = 16'($urandom);
      el = model_apply(kind, d, ew, ea);
      issue(kind, d, n[0], lat, nwr, wa, wd);
      n_checks++;
      if (lat !== el) $display("FAIL rand_latency[%0d] got %0d want %0d", n, lat, el); else n_pass++;
      n_checks++;
      if (nwr !== int'(ew) || (ew && (wa !== ea || wd !== d)))
        $display("FAIL rand_write[%0d] got n=%0d addr=%0d data=%h want n=%0d addr=%0d data=%h",
                 n, nwr, wa, wd, ew, ea, d);
      else n_pass++;
      n_checks++;
      if (op_a !== m_op_a || op_b !== m_op_b)
        $display("FAIL rand_ops[%0d] got a=%h b=%h want a=%h b=%h", n, op_a, op_b, m_op_a, m_op_b);
      else n_pass++;
      n_checks++;
      if ({sp, full, empty, overflow_err, underflow_err} !==
          {6'(m_stack.size()), m_stack.size() == 32, m_stack.size() == 0, m_ovf, m_unf})
        $display("FAIL rand_status[%0d] got sp=%0d f=%b e=%b ov=%b un=%b want sp=%0d ov=%b un=%b",
                 n, sp, full, empty, overflow_err, underflow_err, m_stack.size(), m_ovf, m_unf);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_push_basic();
    test_pop2();
    test_underflow();
    test_fill_overflow();
    test_short_pop2_priority();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
